// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_like_arbiter
// Description : Shares one SRAM-like memory port between the instruction-fetch
//               and data-access requesters. Registers the winning command,
//               presents it on the shared port and routes the response back
//               to the owner. One transaction outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    // instruction-fetch requester
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    // data-access requester
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    // shared port
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Owner / grant encoding: 0 = instruction side, 1 = data side.
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                pick_data;
    logic                accept;
    logic                resp;

    // Winner selection: data side wins when pick_data is set.
    generate
        if (DATA_FIRST != 0) begin : g_data_first
            assign pick_data = data_req;
        end else begin : g_round_robin
            // On a conflict the side not granted last time goes first.
            assign pick_data = data_req & (~inst_req | (last_grant_q == OWN_INST));
        end
    endgenerate

    assign accept = (state_q == S_IDLE) & (inst_req | data_req);
    assign resp   = (state_q == S_WAIT) & data_ok;

    // Acceptance and response pulses are decoded straight from the current state.
    assign inst_addr_ok = accept & ~pick_data;
    assign data_addr_ok = accept &  pick_data;
    assign inst_data_ok = resp & (owner_q == OWN_INST);
    assign data_data_ok = resp & (owner_q == OWN_DATA);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    // The shared-port command comes only from the captured registers.
    assign req   = (state_q == S_ADDR);
    assign wr    = wr_q;
    assign size  = size_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

    // Next-state logic: arbitration and command capture in IDLE, handshake tracking after.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_ADDR;
                    owner_d      = pick_data ? OWN_DATA : OWN_INST;
                    last_grant_d = pick_data ? OWN_DATA : OWN_INST;
                    wr_d         = pick_data ? data_wr    : inst_wr;
                    size_d       = pick_data ? data_size  : inst_size;
                    addr_d       = pick_data ? data_addr  : inst_addr;
                    wdata_d      = pick_data ? data_wdata : inst_wdata;
                end
            end
            S_ADDR: begin
                // A data_ok arriving here is stray and deliberately dropped.
                if (addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (data_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and command registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_INST;
            last_grant_q <= OWN_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_like_arbiter
// Description : Directed self-checking bench. Two instances share stimulus:
//               u_dut0 uses round-robin arbitration, u_dut1 data-first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        i_aok0, i_dok0, d_aok0, d_dok0, req0, wr0;
    logic        i_aok1, i_dok1, d_aok1, d_dok1, req1, wr1;
    logic [1:0]  size0, size1;
    logic [31:0] i_rd0, d_rd0, addr0, wdata0;
    logic [31:0] i_rd1, d_rd1, addr1, wdata1;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard queues: expected grants (pushed on drive) and expected owners.
    bit exp_grant0[$];
    bit exp_grant1[$];
    bit exp_own0[$];
    bit exp_own1[$];

    always #5 clk = ~clk;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(i_aok0), .inst_data_ok(i_dok0), .inst_rdata(i_rd0),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(d_aok0), .data_data_ok(d_dok0), .data_rdata(d_rd0),
        .req(req0), .wr(wr0), .size(size0), .addr(addr0), .wdata(wdata0),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(i_aok1), .inst_data_ok(i_dok1), .inst_rdata(i_rd1),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(d_aok1), .data_data_ok(d_dok1), .data_rdata(d_rd1),
        .req(req1), .wr(wr1), .size(size1), .addr(addr1), .wdata(wdata1),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Full transaction: accept, aw cycles of backpressure, dw idle WAIT cycles, response.
    task automatic txn(input string name, input bit ir, input bit dr, input bit hold,
                       input int aw, input int dw, input logic [31:0] rd,
                       input bit eg0, input bit eg1);
        bit          g0, g1, o0, o1;
        logic        ew0, ew1;
        logic [1:0]  es0, es1;
        logic [31:0] ea0, ea1, ed0, ed1;
        logic [31:0] sv_ia, sv_iw, sv_da, sv_dw;
        exp_grant0.push_back(eg0);
        exp_grant1.push_back(eg1);
        inst_req = ir;
        data_req = dr;
        #1;
        g0 = exp_grant0.pop_front();
        g1 = exp_grant1.pop_front();
        chk({name, "/grant0"}, {d_aok0, i_aok0}, g0 ? 2'b10 : 2'b01);
        chk({name, "/grant1"}, {d_aok1, i_aok1}, g1 ? 2'b10 : 2'b01);
        ew0 = g0 ? data_wr : inst_wr;       ew1 = g1 ? data_wr : inst_wr;
        es0 = g0 ? data_size : inst_size;   es1 = g1 ? data_size : inst_size;
        ea0 = g0 ? data_addr : inst_addr;   ea1 = g1 ? data_addr : inst_addr;
        ed0 = g0 ? data_wdata : inst_wdata; ed1 = g1 ? data_wdata : inst_wdata;
        exp_own0.push_back(g0);
        exp_own1.push_back(g1);
        sv_ia = inst_addr; sv_iw = inst_wdata; sv_da = data_addr; sv_dw = data_wdata;
        @(negedge clk);
        if (!hold) begin
            // Dropping requests and changing inputs must not disturb the captured command.
            inst_req = 1'b0; data_req = 1'b0;
            inst_addr = ~inst_addr; inst_wdata = ~inst_wdata;
            data_addr = ~data_addr; data_wdata = ~data_wdata;
        end
        for (int i = 0; i <= aw; i++) begin
            if (i == aw) addr_ok = 1'b1;
            else if (i == 0) data_ok = 1'b1;
            #1;
            chk({name, "/cmd0"}, {req0, wr0, size0, addr0, wdata0}, {1'b1, ew0, es0, ea0, ed0});
            chk({name, "/cmd1"}, {req1, wr1, size1, addr1, wdata1}, {1'b1, ew1, es1, ea1, ed1});
            chk({name, "/aok_addr"}, {i_aok0, d_aok0, i_aok1, d_aok1}, 4'b0000);
            chk({name, "/dok_addr"}, {i_dok0, d_dok0, i_dok1, d_dok1}, 4'b0000);
            @(negedge clk);
            addr_ok = 1'b0;
            data_ok = 1'b0;
        end
        for (int i = 0; i <= dw; i++) begin
            if (i == dw) begin
                data_ok = 1'b1;
                rdata   = rd;
            end
            #1;
            chk({name, "/req_wait"}, {req0, req1}, 2'b00);
            chk({name, "/aok_wait"}, {i_aok0, d_aok0, i_aok1, d_aok1}, 4'b0000);
            if (i == dw) begin
                o0 = exp_own0.pop_front();
                o1 = exp_own1.pop_front();
                chk({name, "/resp0"}, {d_dok0, i_dok0}, o0 ? 2'b10 : 2'b01);
                chk({name, "/resp1"}, {d_dok1, i_dok1}, o1 ? 2'b10 : 2'b01);
                chk({name, "/rdata"}, {i_rd0, d_rd0, i_rd1, d_rd1}, {4{rd}});
            end else begin
                chk({name, "/dok_early"}, {i_dok0, d_dok0, i_dok1, d_dok1}, 4'b0000);
            end
            @(negedge clk);
            data_ok = 1'b0;
        end
        inst_addr = sv_ia; inst_wdata = sv_iw; data_addr = sv_da; data_wdata = sv_dw;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'h0BFC_0000; inst_wdata = 32'h1111_1111;
        data_req = 1'b0; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst/port0", {req0, wr0, size0, addr0, wdata0}, 68'h0);
        chk("rst/port1", {req1, wr1, size1, addr1, wdata1}, 68'h0);
        chk("rst/oks", {i_aok0, d_aok0, i_dok0, d_dok0, i_aok1, d_aok1, i_dok1, d_dok1}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Stray handshakes in IDLE must be ignored.
        addr_ok = 1'b1; data_ok = 1'b1;
        #1;
        chk("idle_stray/dok", {i_dok0, d_dok0, i_dok1, d_dok1}, 4'b0000);
        @(negedge clk);
        addr_ok = 1'b0; data_ok = 1'b0;
        #1;
        chk("idle_stray/req", {req0, req1}, 2'b00);

        // Lone data write, addr_ok at T+1, data_ok at T+3.
        txn("lone_data", 1'b0, 1'b1, 1'b0, 0, 1, 32'h0, 1'b1, 1'b1);

        // Conflicts from a fresh reset: round-robin alternates, data-first never yields.
        do_reset();
        txn("conf1", 1'b1, 1'b1, 1'b1, 0, 0, 32'hA, 1'b1, 1'b1);
        txn("conf2", 1'b1, 1'b1, 1'b1, 0, 0, 32'hB, 1'b0, 1'b1);
        txn("conf3", 1'b1, 1'b1, 1'b1, 0, 0, 32'hC, 1'b1, 1'b1);
        txn("conf4", 1'b1, 1'b1, 1'b1, 0, 0, 32'hD, 1'b0, 1'b1);

        // Slave backpressure for 5 cycles.
        data_addr = 32'h0000_2004; data_wdata = 32'hCAFE_F00D;
        txn("bkpr", 1'b0, 1'b1, 1'b0, 5, 0, 32'h0, 1'b1, 1'b1);

        // Instruction read.
        txn("inst_rd", 1'b1, 1'b0, 1'b0, 0, 2, 32'h3C1D_0001, 1'b0, 1'b0);

        // Reset while in WAIT discards the transaction.
        data_req = 1'b1;
        #1;
        chk("rstw/grant", {d_aok0, i_aok0, d_aok1, i_aok1}, 4'b1010);
        @(negedge clk);
        data_req = 1'b0;
        addr_ok = 1'b1;
        @(negedge clk);
        addr_ok = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstw/req", {req0, req1}, 2'b00);
        chk("rstw/cmd", {addr0, wdata0, addr1, wdata1}, 128'h0);
        data_ok = 1'b1; rdata = 32'h5555_AAAA;
        #1;
        chk("rstw/late_dok", {i_dok0, d_dok0, i_dok1, d_dok1}, 4'b0000);
        @(negedge clk);
        data_ok = 1'b0;

        // Recovery after reset.
        txn("recover", 1'b1, 1'b0, 1'b0, 1, 0, 32'h1234_5678, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
